srpq_cell_array: RTL and testbench
==================================

// Module: srpq_cell_array
// PURPOSE
//   Shift-register priority queue: sorted array of DEPTH entries, each held in
//   enable flops, with enqueue/dequeue commands from the Quick Priority Queue
//   controller. Entry 0 always holds the minimum key. It drives it as the head.
//   Sits directly downstream of the request register stage. It consumes one
//   enq/deq command per cycle and exposes head/status to the consumer.
// PARAMETERS
//   KW     8   key (priority) width, unsigned; smaller key = higher priority
//   DW     8   payload width carried with each key
//   DEPTH  8   number of entries (>=2); CW = $clog2(DEPTH+1) count width
// PORTS
//   clk       in   1    clock, all state updates on posedge
//   rst       in   1    synchronous active-high reset
//   enq       in   1    insert {enq_key,enq_data} this cycle
//   enq_key   in   KW   key to insert
//   enq_data  in   DW   payload to insert
//   deq       in   1    remove head entry this cycle
//   head_key  out  KW   key of entry 0 (valid when !empty)
//   head_data out  DW   payload of entry 0
//   empty     out  1    count==0
//   full      out  1    count==DEPTH
//   count     out  CW   number of valid entries
//   ovf       out  1    1-cycle pulse: enq dropped (full, no deq)
//   udf       out  1    1-cycle pulse: deq ignored (empty)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high (clk, rst).
//   - Reset: all entries invalid, key/data cleared to 0. count=0, empty=1,
//     full=0. head_key=0, head_data=0. ovf=0, udf=0. rst wins over enq/deq.
//   - All outputs come from registers. A command in cycle N is reflected in
//     the outputs in cycle N+1. Commands are accepted every cycle, with no
//     stall.
//   - Per entry i: valid bit, key, data. Valid entries are contiguous from 0,
//     with keys non-decreasing.
//   - enq only: insert position p = first i where !valid[i] or
//     key[i] > enq_key. Entries p..DEPTH-2 shift to i+1. Entry p gets the new
//     value. count+1.
//   - Equal keys are FIFO: new entry goes after all existing equal keys
//     (strict >).
//   - deq only: entries 1..DEPTH-1 shift to i-1. The last entry becomes
//     invalid and is cleared to 0. count-1.
//   - enq+deq same cycle, count>=1: head removed and new item inserted in the
//     same update. count unchanged. Legal when full. The new item may become
//     the head.
//   - enq when full without deq: queue unchanged, ovf=1 next cycle.
//   - deq when empty: udf=1 next cycle. If enq is also set, the item is
//     inserted normally (count 0->1).
//   - Invalid entries read as key=0, data=0. head_* = 0 whenever empty.
//   - count never exceeds DEPTH and never wraps below 0.
// TESTING
//   1. rst=1 two cycles with enq=1 -> count=0, empty=1, head_key=0, ovf=udf=0.
//   2. enq keys 5,2,9,2(data A,B,C,D) -> head 2/B. deq sequence yields
//      2/B,2/D,5/A,9/C. Then empty=1.
//   3. enq 8 keys 8..1, DEPTH=8 -> full=1, count=8. enq key 0 alone -> ovf=1,
//      queue unchanged, head=1.
//   4. full queue, enq key 0 + deq same cycle -> count=8, head_key=0.
//      Next deq -> head_key=2.
//   5. empty: deq alone -> udf=1, count=0. deq+enq key 7 -> udf=1, count=1,
//      head_key=7.
//   6. 4 entries loaded, rst asserted with enq+deq -> all cleared next cycle,
//      count=0.

Source files
------------

// File: rtl/srpq_cell_array.sv
// Shift-register priority queue: sorted enable-flop array, entry 0 holds the minimum key.
// One enq/deq command is accepted per cycle and shows up in the registered outputs on the next cycle.
module srpq_cell_array #(
  parameter  int KW    = 8,
  parameter  int DW    = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic [KW-1:0] enq_key,
  input  logic [DW-1:0] enq_data,
  input  logic          deq,
  output logic [KW-1:0] head_key,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          udf
);

  logic [DEPTH-1:0]         valid_q, valid_d, valid_b, ins;
  logic [DEPTH-1:0][KW-1:0] key_q, key_d, key_b;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d, data_b;
  logic [CW-1:0]            count_q, count_d;
  logic                     empty_q, full_q, ovf_q, udf_q;
  logic                     do_deq, do_enq;

  always_comb begin
    do_deq = deq && (count_q != '0);
    do_enq = enq && ((count_q != CW'(DEPTH)) || do_deq);

    // Apply the dequeue shift first, then insert into the shifted image.
    valid_b = valid_q;
    key_b   = key_q;
    data_b  = data_q;
    if (do_deq) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        valid_b[i] = valid_q[i+1];
        key_b[i]   = key_q[i+1];
        data_b[i]  = data_q[i+1];
      end
      valid_b[DEPTH-1] = 1'b0;
      key_b[DEPTH-1]   = '0;
      data_b[DEPTH-1]  = '0;
    end

    // ins is monotone (sorted, contiguous); its first set bit is the insert slot.
    for (int unsigned i = 0; i < DEPTH; i++)
      ins[i] = !valid_b[i] || (key_b[i] > enq_key);

    valid_d = valid_b;
    key_d   = key_b;
    data_d  = data_b;
    if (do_enq) begin
      if (ins[0]) begin
        valid_d[0] = 1'b1;
        key_d[0]   = enq_key;
        data_d[0]  = enq_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (ins[i] && !ins[i-1]) begin
          valid_d[i] = 1'b1;
          key_d[i]   = enq_key;
          data_d[i]  = enq_data;
        end else if (ins[i]) begin
          valid_d[i] = valid_b[i-1];
          key_d[i]   = key_b[i-1];
          data_d[i]  = data_b[i-1];
        end
      end
    end

    count_d = count_q + CW'(do_enq) - CW'(do_deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      key_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      data_q  <= data_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(DEPTH));
      ovf_q   <= enq && !deq && (count_q == CW'(DEPTH));
      udf_q   <= deq && (count_q == '0);
    end
  end

  assign head_key  = key_q[0];
  assign head_data = data_q[0];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_srpq_cell_array.sv
// Bench for srpq_cell_array: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_srpq_cell_array;
  localparam int KW = 8, DW = 8, DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, enq, deq;
  logic [KW-1:0] enq_key, head_key;
  logic [DW-1:0] enq_data, head_data;
  logic          empty, full, ovf, udf;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  srpq_cell_array #(.KW(KW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enq(enq), .enq_key(enq_key), .enq_data(enq_data),
    .deq(deq), .head_key(head_key), .head_data(head_data), .empty(empty),
    .full(full), .count(count), .ovf(ovf), .udf(udf)
  );

  typedef struct { logic [KW-1:0] key; logic [DW-1:0] data; } item_t;
  item_t mq[$];
  logic  m_ovf, m_udf;

  // Reference: sorted list; equal keys keep arrival order.
  task automatic model_step(input logic r, input logic e, input logic d,
                            input logic [KW-1:0] k, input logic [DW-1:0] dt);
    int idx;
    item_t it;
    bit was_full;
    if (r) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    m_ovf = e && !d && was_full;
    m_udf = d && (mq.size() == 0);
    if (d && mq.size() > 0) void'(mq.pop_front());
    if (e && mq.size() < DEPTH) begin
      idx = mq.size();
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].key > k) idx = i;
      it.key  = k;
      it.data = dt;
      mq.insert(idx, it);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic d,
                       input logic [KW-1:0] k, input logic [DW-1:0] dt);
    rst = r; enq = e; deq = d; enq_key = k; enq_data = dt;
    model_step(r, e, d, k, dt);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    int hk, hd;
    hk = (mq.size() > 0) ? int'(mq[0].key)  : 0;
    hd = (mq.size() > 0) ? int'(mq[0].data) : 0;
    chk({tag, ".count"}, int'(count), mq.size());
    chk({tag, ".head_key"}, int'(head_key), hk);
    chk({tag, ".head_data"}, int'(head_data), hd);
    chk({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
    chk({tag, ".full"}, int'(full), int'(mq.size() == DEPTH));
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, ".udf"}, int'(udf), int'(m_udf));
  endtask

  typedef struct {
    logic r, e, d;
    logic [KW-1:0] k;
    logic [DW-1:0] dt;
    int cnt, hk, hd;
    logic ov, ud;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   fk;
    string nm;

    // rst enq deq key data | count head_key head_data ovf udf
    vt.push_back('{1, 1, 0, 8'd3,  8'h33, 0, 0,  0,     0, 0});
    vt.push_back('{1, 1, 1, 8'd3,  8'h33, 0, 0,  0,     0, 0});
    vt.push_back('{0, 1, 0, 8'd5,  8'h0A, 1, 5,  'h0A,  0, 0});
    vt.push_back('{0, 1, 0, 8'd2,  8'h0B, 2, 2,  'h0B,  0, 0});
    vt.push_back('{0, 1, 0, 8'd9,  8'h0C, 3, 2,  'h0B,  0, 0});
    vt.push_back('{0, 1, 0, 8'd2,  8'h0D, 4, 2,  'h0B,  0, 0});
    vt.push_back('{0, 0, 1, 8'd0,  8'h00, 3, 2,  'h0D,  0, 0});
    vt.push_back('{0, 0, 1, 8'd0,  8'h00, 2, 5,  'h0A,  0, 0});
    vt.push_back('{0, 0, 1, 8'd0,  8'h00, 1, 9,  'h0C,  0, 0});
    vt.push_back('{0, 0, 1, 8'd0,  8'h00, 0, 0,  0,     0, 0});
    vt.push_back('{0, 0, 1, 8'd0,  8'h00, 0, 0,  0,     0, 1});
    vt.push_back('{0, 1, 1, 8'd7,  8'h77, 1, 7,  'h77,  0, 1});
    vt.push_back('{0, 0, 1, 8'd0,  8'h00, 0, 0,  0,     0, 0});

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].r, vt[i].e, vt[i].d, vt[i].k, vt[i].dt);
      nm = $sformatf("vec%0d", i);
      chk({nm, ".count"}, int'(count), vt[i].cnt);
      chk({nm, ".head_key"}, int'(head_key), vt[i].hk);
      chk({nm, ".head_data"}, int'(head_data), vt[i].hd);
      chk({nm, ".empty"}, int'(empty), int'(vt[i].cnt == 0));
      chk({nm, ".full"}, int'(full), int'(vt[i].cnt == DEPTH));
      chk({nm, ".ovf"}, int'(ovf), int'(vt[i].ov));
      chk({nm, ".udf"}, int'(udf), int'(vt[i].ud));
    end

    // Fill with keys 8..1, then overflow attempt with key 0.
    apply(1, 0, 0, 0, 0);
    for (int i = 8; i >= 1; i--) begin
      fk = i;
      apply(0, 1, 0, KW'(fk), DW'(fk + 'h10));
      chk("fill.count", int'(count), 9 - i);
      chk("fill.head_key", int'(head_key), i);
    end
    chk("fill.full", int'(full), 1);
    apply(0, 1, 0, 8'd0, 8'hEE);
    chk("ovf.pulse", int'(ovf), 1);
    chk("ovf.count", int'(count), 8);
    chk("ovf.head_key", int'(head_key), 1);
    chk("ovf.head_data", int'(head_data), 'h11);
    apply(0, 0, 0, 0, 0);
    chk("ovf.clear", int'(ovf), 0);

    // Full queue: simultaneous enq key 0 and deq.
    apply(0, 1, 1, 8'd0, 8'hEE);
    chk("swap.count", int'(count), 8);
    chk("swap.full", int'(full), 1);
    chk("swap.ovf", int'(ovf), 0);
    chk("swap.head_key", int'(head_key), 0);
    chk("swap.head_data", int'(head_data), 'hEE);
    apply(0, 0, 1, 0, 0);
    chk("swap_deq.head_key", int'(head_key), 2);
    chk("swap_deq.count", int'(count), 7);

    // Reset dominates a concurrent enq+deq on a partly loaded queue.
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply(0, 1, 0, KW'(10 + i), DW'(i));
    chk("load4.count", int'(count), 4);
    apply(1, 1, 1, 8'd1, 8'h01);
    chk("rstcmd.count", int'(count), 0);
    chk("rstcmd.empty", int'(empty), 1);
    chk("rstcmd.head_key", int'(head_key), 0);
    chk("rstcmd.head_data", int'(head_data), 0);

    // Random traffic; small key range forces many ties.
    for (int c = 0; c < 1500; c++) begin
      logic r, e, d;
      int pe;
      pe = ((c / 150) % 2 == 0) ? 75 : 30;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 99) < pe);
      d = ($urandom_range(0, 99) < (100 - pe));
      apply(r, e, d, KW'($urandom_range(0, 15)), DW'($urandom));
      chk_model($sformatf("rnd%0d", c));
    end

    rst = 0; enq = 0; deq = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
